// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO: fetch, load, then send
// start, 8 data bits LSB first, optional even parity, and one stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdout,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_CLK = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic             fetch_ok;
    logic             bit_end;

    assign fetch_ok = enable && !fifo_empty;
    assign bit_end  = (clk_cnt == LAST_CLK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_ren   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            clk_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            fifo_ren <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    tx      <= 1'b1;
                    if (fetch_ok) begin
                        state    <= FETCH;
                        fifo_ren <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // Read data is valid exactly in this cycle, one edge after fifo_ren was sampled.
                    shift_reg  <= fifo_rdout;
                    parity_bit <= ^fifo_rdout;
                    bit_cnt    <= '0;
                    clk_cnt    <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // tx_done is registered, so it is raised one cycle early to land on the last stop cycle.
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (fetch_ok) begin
                            state    <= FETCH;
                            fifo_ren <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                        tx_done <= (clk_cnt == DONE_CLK);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) at 4 clocks per bit,
// each fed by a simple FIFO model and checked against a per-frame bit model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, en1;
    logic       ren0, ren1, tx0, tx1, busy0, busy1, done0, done1;
    logic       empty0, empty1;
    logic [7:0] rdout0 = '0;
    logic [7:0] rdout1 = '0;

    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int ren_cnt0 = 0, ren_cnt1 = 0, under0 = 0, under1 = 0;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .fifo_empty(empty0),
        .fifo_rdout(rdout0), .fifo_ren(ren0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(empty1),
        .fifo_rdout(rdout1), .fifo_ren(ren1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    always #5 clk = ~clk;

    assign empty0 = (rd0 == wr0);
    assign empty1 = (rd1 == wr1);

    // FIFO models: read data registered on the edge that samples the read enable
    always @(posedge clk) begin
        if (ren0) begin
            ren_cnt0 <= ren_cnt0 + 1;
            if (rd0 == wr0) under0 <= under0 + 1;
            else begin
                rdout0 <= mem0[rd0 % 64];
                rd0    <= rd0 + 1;
            end
        end
        if (ren1) begin
            ren_cnt1 <= ren_cnt1 + 1;
            if (rd1 == wr1) under1 <= under1 + 1;
            else begin
                rdout1 <= mem1[rd1 % 64];
                rd1    <= rd1 + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int d);   return (d == 0) ? tx0   : tx1;   endfunction
    function automatic logic get_busy(input int d); return (d == 0) ? busy0 : busy1; endfunction
    function automatic logic get_done(input int d); return (d == 0) ? done0 : done1; endfunction
    function automatic logic get_ren(input int d);  return (d == 0) ? ren0  : ren1;  endfunction

    // Line level expected for bit slot i of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int par, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (par != 0 && i == 9) return logic'($countones(b) % 2);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        if (d == 0) begin mem0[wr0 % 64] = b; wr0++; end
        else        begin mem1[wr1 % 64] = b; wr1++; end
    endtask

    task automatic set_en(input int d, input logic v);
        if (d == 0) en0 = v; else en1 = v;
    endtask

    task automatic wait_ren(input int d, input int maxc, output bit found);
        found = 1'b0;
        for (int c = 0; c < maxc && !found; c++) begin
            @(negedge clk);
            if (get_ren(d) === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_fall(input int d, input int maxc, output int n, output bit found);
        found = 1'b0;
        n = 0;
        while (!found && n < maxc) begin
            @(negedge clk);
            n++;
            if (get_tx(d) === 1'b0) found = 1'b1;
        end
    endtask

    // Entered at the first start-bit cycle; checks every cycle of the frame
    task automatic recv_frame(input int d, input logic [7:0] b, input int drop_at);
        int par = d;
        int nb  = 10 + par;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i != 0 || k != 0) @(negedge clk);
                if (i * 4 + k == drop_at) set_en(d, 1'b0);
                chk("tx_bit", get_tx(d), frame_bit(b, par, i));
                chk("tx_done", get_done(d), (i == nb - 1) && (k == 3));
                chk("busy_in_frame", get_busy(d), 1'b1);
            end
        end
    endtask

    initial begin
        bit         f;
        int         n;
        logic [7:0] rb [4];
        logic [7:0] x, y, z;

        rst_n = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", tx0, 1'b1);     chk("rst_tx1", tx1, 1'b1);
        chk("rst_busy0", busy0, 1'b0); chk("rst_busy1", busy1, 1'b0);
        chk("rst_ren0", ren0, 1'b0);   chk("rst_ren1", ren1, 1'b0);
        chk("rst_done0", done0, 1'b0); chk("rst_done1", done1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        push(0, 8'hA5);
        en0 = 1'b1;
        wait_ren(0, 10, f);
        chk("single_ren_seen", f, 1'b1);
        wait_fall(0, 10, n, f);
        chk("single_fall_seen", f, 1'b1);
        chkn("fetch_to_start", n, 2);
        recv_frame(0, 8'hA5, -1);
        @(negedge clk);
        chk("single_busy_after", busy0, 1'b0);
        chk("single_tx_after", tx0, 1'b1);
        chkn("single_ren_count", ren_cnt0, 1);

        // Back-to-back 0x01, 0x02, 0x03
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            wait_fall(0, 10, n, f);
            chk("b2b_fall_seen", f, 1'b1);
            if (i > 0) chkn("b2b_gap", n, 3);
            recv_frame(0, 8'(i + 1), -1);
        end
        @(negedge clk);
        chk("b2b_busy_after", busy0, 1'b0);
        chkn("b2b_ren_count", ren_cnt0, 4);
        chk("b2b_empty", empty0, 1'b1);

        // Empty FIFO with enable held high
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("empty_ren", ren0, 1'b0);
            chk("empty_tx", tx0, 1'b1);
            chk("empty_busy", busy0, 1'b0);
        end

        // Parity instance: 0x07 (parity 1), 0x03 (parity 0), then random bytes
        en1 = 1'b1;
        push(1, 8'h07);
        wait_fall(1, 10, n, f);
        chk("par_fall_seen", f, 1'b1);
        chkn("par_fetch_to_start", n, 3);
        recv_frame(1, 8'h07, -1);
        push(1, 8'h03);
        wait_fall(1, 10, n, f);
        chk("par_fall_seen2", f, 1'b1);
        recv_frame(1, 8'h03, -1);
        for (int i = 0; i < 4; i++) rb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) push(1, rb[i]);
        for (int i = 0; i < 4; i++) begin
            wait_fall(1, 10, n, f);
            chk("rand_fall_seen", f, 1'b1);
            if (i > 0) chkn("rand_gap", n, 3);
            recv_frame(1, rb[i], -1);
        end
        @(negedge clk);
        chk("par_busy_after", busy1, 1'b0);
        chkn("par_ren_count", ren_cnt1, 6);
        en1 = 1'b0;

        // Enable dropped during DATA with two bytes queued
        en0 = 1'b0;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        push(0, x); push(0, y);
        en0 = 1'b1;
        wait_fall(0, 10, n, f);
        chk("drop_fall_seen", f, 1'b1);
        recv_frame(0, x, 12);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("drop_no_ren", ren0, 1'b0);
        end
        chk("drop_busy_after", busy0, 1'b0);
        chkn("drop_ren_count", ren_cnt0, 5);
        chkn("drop_fifo_level", wr0 - rd0, 1);

        // Reset pulsed during DATA; the next queued byte must still go out whole
        z = 8'($urandom_range(0, 255));
        push(0, z);
        en0 = 1'b1;
        wait_fall(0, 10, n, f);
        chk("rst_fall_seen", f, 1'b1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx0, 1'b1);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_ren", ren0, 1'b0);
        chk("midrst_done", done0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fall(0, 10, n, f);
        chk("post_rst_fall_seen", f, 1'b1);
        recv_frame(0, z, -1);
        @(negedge clk);
        chk("post_rst_busy", busy0, 1'b0);
        chk("post_rst_empty", empty0, 1'b1);
        chkn("underflow", under0 + under1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains bytes from the synchronous FIFO read port and sends each one as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO: it drives the FIFO read enable, consumes the registered read data, and never reads while the FIFO reports empty, so it can never cause FIFO underflow.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new byte fetches; sampled only when a fetch could start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdout  in  8  FIFO read data; valid the cycle after the edge that samples fifo_ren=1.
- fifo_ren  out  1  FIFO read enable; registered; one-cycle pulse per byte.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state ≠ IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Reset values: state=IDLE, fifo_ren=0, tx=1, busy=0, tx_done=0, bit counter=0, clock counter=0, shift register=0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if enable=1 and fifo_empty=0 → FETCH; otherwise stay in IDLE.
- FETCH: fifo_ren=1 for exactly this cycle → LOAD unconditionally.
- LOAD: fifo_rdout is captured into the shift register; parity = XOR of the 8 bits → START.
- START: tx=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; the 3-bit counter reaches 7 and then → PARITY if PARITY_EN=1, else → STOP.
- PARITY: tx = even-parity bit (total number of ones across data and parity is even) for CLKS_PER_BIT cycles → STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done pulses during the final cycle. Then → FETCH if enable=1 and fifo_empty=0; otherwise → IDLE.
- Clock counter: counts 0..CLKS_PER_BIT-1 within each bit and resets to 0 on every state change. Its width is $clog2(CLKS_PER_BIT).
- tx is registered. It holds 1 in IDLE, FETCH and LOAD.
- Boundary conditions:
  - enable deasserted mid-frame: the current frame completes intact; no new fetch starts.
  - fifo_empty rising during a frame: no effect until the next fetch decision.
  - fifo_empty is ignored outside the IDLE and STOP-exit decision points.
  - fifo_ren is never asserted while fifo_empty=1 at the decision edge.
  - Reset mid-frame: all outputs return to their reset values immediately and asynchronously (tx=1); the in-flight byte is dropped.

## Timing
- Decision edge E0 (IDLE or STOP exit) → fifo_ren high from E0 to E1.
- FIFO samples fifo_ren at E1; fifo_rdout is valid from E1 to E2.
- Shift register loads at E2; tx falls after E2.
- Fetch-to-start latency: 2 cycles after the decision edge.
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the tx falling edge to the end of the stop bit.
- Back-to-back bytes: exactly 2 idle-high cycles (FETCH, LOAD) between the end of one stop bit and the next start bit.
- Throughput: one byte per (10 + PARITY_EN) × CLKS_PER_BIT + 2 cycles.
- busy: rises the cycle after E0 and falls the cycle after the final STOP cycle, unless the block chains directly into FETCH.
- tx_done: high for 1 cycle per frame, coincident with the last stop-bit cycle.

## Test plan
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5:
  - one fifo_ren pulse.
  - tx falls 2 cycles after fetch.
  - bits 1,0,1,0,0,1,0,1 each held 4 cycles; stop held 4 cycles.
  - tx_done pulses once; busy=0 afterwards.
- Back-to-back, FIFO holds 0x01, 0x02, 0x03:
  - three frames separated by exactly 2 high cycles.
  - three fifo_ren pulses; no fifo_ren once fifo_empty=1.
- Empty FIFO with enable=1 for 100 cycles: fifo_ren=0, tx=1, busy=0 throughout.
- PARITY_EN=1, byte 0x07: parity bit=1, frame is 44 cycles at CLKS_PER_BIT=4; byte 0x03: parity bit=0.
- enable dropped during DATA with 2 bytes queued: the current frame completes, no further fifo_ren, and the FIFO still holds 1 byte.
- rst_n pulsed low during DATA: tx=1, busy=0, fifo_ren=0 immediately. After release, the next queued byte transmits as a complete frame.
